// File: rtl/alu_issue_scheduler_pkg.sv
// Shared rename/issue types: ROB tag, RS entry count, one-hot entry vector.
// Imported by alu_issue_scheduler, oldest_select, renameStage and RSArbiter.
package alu_issue_scheduler_pkg;

  localparam int RS_N  = 4;
  localparam int ROB_W = 3;

  typedef logic [ROB_W-1:0] rob_tag_t;
  typedef logic [RS_N-1:0]  rs_vec_t;

  function automatic logic tag_hit(
    input logic     vld,
    input rob_tag_t a,
    input rob_tag_t b
  );
    return vld && (a == b);
  endfunction

endpackage

// File: rtl/oldest_select.sv
// Oldest-ready picker: grants the requester older than all other requesters.
// Ports: req (request vector), older (age matrix), grant (one-hot or zero).
module oldest_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [N-1:0][N-1:0] older,
  output logic [N-1:0]        grant
);

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = req[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && req[j] && !older[i][j])
          grant[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// ALU reservation station: operand wakeup, age-ordered issue, flush.
// Ports: clk, rst_n, allocReq/ready/rob (dispatch), cdb*, fuReady, flush,
//        issueValid/issueGrant (select), ALUBusyVector (occupancy).
module alu_issue_scheduler
  import alu_issue_scheduler_pkg::*;
#(
  parameter int ALU = RS_N - 1,
  parameter int ROB = ROB_W - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [ALU:0] allocReq,
  input  logic         ready1,
  input  logic         ready2,
  input  logic [ROB:0] rob1,
  input  logic [ROB:0] rob2,
  input  logic         cdbValid,
  input  logic [ROB:0] cdbTag,
  input  logic         fuReady,
  input  logic         flush,
  output logic         issueValid,
  output logic [ALU:0] issueGrant,
  output logic [ALU:0] ALUBusyVector
);

  localparam int N = ALU + 1;

  logic [ALU:0]           valid;
  logic [ALU:0]           rdy1;
  logic [ALU:0]           rdy2;
  logic [ALU:0][ROB:0]    tag1;
  logic [ALU:0][ROB:0]    tag2;
  logic [ALU:0][ALU:0]    older;
  logic [ALU:0]           req;
  logic [ALU:0]           sel;
  logic [ALU:0]           alloc;
  logic                   byp1;
  logic                   byp2;

  assign req = valid & rdy1 & rdy2;

  oldest_select #(.N(N)) u_sel (
    .req   (req),
    .older (older),
    .grant (sel)
  );

  assign issueValid    = rst_n & fuReady & (|req);
  assign issueGrant    = issueValid ? sel : '0;
  assign ALUBusyVector = rst_n ? valid : '0;

  // Writes into occupied entries are dropped, even if granted this cycle.
  assign alloc = allocReq & ~valid;
  assign byp1  = cdbValid && (cdbTag == rob1);
  assign byp2  = cdbValid && (cdbTag == rob2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      rdy1  <= '0;
      rdy2  <= '0;
      tag1  <= '0;
      tag2  <= '0;
      older <= '0;
    end else if (flush) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (valid[i] && cdbValid && cdbTag == tag1[i])
          rdy1[i] <= 1'b1;
        if (valid[i] && cdbValid && cdbTag == tag2[i])
          rdy2[i] <= 1'b1;
        if (issueGrant[i])
          valid[i] <= 1'b0;
        if (alloc[i]) begin
          valid[i] <= 1'b1;
          rdy1[i]  <= ready1 | byp1;
          rdy2[i]  <= ready2 | byp2;
          tag1[i]  <= rob1;
          tag2[i]  <= rob2;
          older[i] <= '0;
          // New entry is youngest: every live entry becomes older than it.
          for (int j = 0; j < N; j++)
            older[j][i] <= valid[j];
        end
      end
    end
  end

endmodule

// File: doc/alu_issue_scheduler.md
ALU_ISSUE_SCHEDULER -- requirements
Module: alu_issue_scheduler

Interface
REQ-001 SHALL have parameter ALU, default 3, meaning ALU reservation-station entry count minus one (4 entries).
REQ-002 SHALL have parameter ROB, default 2, meaning ROB tag MSB (3-bit tags).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 allocReq  input  ALU+1  one-hot entry being written by dispatch; same encoding as the arbiter's ALURequests.
REQ-006 ready1, ready2  input  1 each  operand-ready flags of the dispatching instruction.
REQ-007 rob1, rob2  input  ROB+1 each  producer ROB tags for non-ready operands.
REQ-008 cdbValid  input  1  common data bus broadcast valid.
REQ-009 cdbTag  input  ROB+1  ROB tag of the broadcast result.
REQ-010 fuReady  input  1  ALU accepts an instruction this cycle.
REQ-011 flush  input  1  misprediction redirect; kill all entries.
REQ-012 issueValid  output  1  one entry is granted this cycle.
REQ-013 issueGrant  output  ALU+1  one-hot granted entry; all zero when issueValid=0.
REQ-014 ALUBusyVector  output  ALU+1  per-entry occupied flag, fed back to the RS arbiter.

Function
REQ-015 Each entry SHALL hold registered valid, rdy1, rdy2, tag1 and tag2.
REQ-016 Allocation at edge N SHALL set valid, capture rdy/tag, and make the entry youngest in the age matrix.
REQ-017 Age matrix older[i][j]=1 SHALL mean entry i is older than entry j; on allocating i, older[j][i]=1 for every valid j and older[i][j]=0.
REQ-018 Wakeup: for each valid entry, cdbValid with cdbTag==tagK SHALL set rdyK at the next edge.
REQ-019 Bypass: if allocation coincides with a CDB match on rob1/rob2, the corresponding rdy SHALL be stored as 1.
REQ-020 Request for an entry SHALL be valid & rdy1 & rdy2, computed from registered state only.
REQ-021 Select is combinational: issueGrant SHALL be the requesting entry older than every other requesting entry, and issueValid SHALL be 1 iff any request and fuReady.
REQ-022 When fuReady=0, issueValid=0 and issueGrant=0, with no state change due to select.
REQ-023 A granted entry SHALL clear valid at the next edge; ALUBusyVector SHALL equal the registered valid bits.
REQ-024 Latency: an entry allocated with both operands ready at edge N SHALL be grantable in cycle N+1; one woken by a CDB in cycle M SHALL be grantable no earlier than cycle M+1.
REQ-025 Allocating into an entry whose valid=1 SHALL be illegal, including an entry granted in the same cycle; the bench asserts on it, and the RTL SHALL ignore the write.
REQ-026 flush SHALL clear all valid bits at the next edge, with priority over allocation and grant; issueValid SHALL still reflect the current cycle.
REQ-027 Full: all four valid SHALL be handled with no special case; ALUBusyVector=4'b1111 blocks allocation upstream.
REQ-028 Empty: issueValid=0 and issueGrant=0 regardless of fuReady.

Reset
REQ-029 With rst_n=0 at an edge, all valid, rdy and age bits SHALL clear and tags SHALL go to 0.
REQ-030 While rst_n=0, issueValid=0, issueGrant=0 and ALUBusyVector=0.
REQ-031 Reset mid-operation SHALL discard all entries, and no grant SHALL appear in the cycle after reset is released.

Structure
REQ-032 A shared package SHALL hold the ROB tag type, the RS entry count and the one-hot entry-vector type, also used by renameStage and RSArbiter.
REQ-033 Oldest-ready selection SHALL be a sub-module oldest_select (inputs: request vector and age matrix; output: one-hot grant); entry state stays in alu_issue_scheduler.

Verification
REQ-034 Alloc entry 0 at edge 1 (ready1=ready2=1) with fuReady=1 -> issueGrant=4'b0001 in cycle 2; ALUBusyVector=0 after edge 2.
REQ-035 Alloc entries 2, 0, 1 in order, all ready, fuReady held 0 then set 1 -> grants 4'b0100, 4'b0001, 4'b0010 on consecutive cycles.
REQ-036 Entry 1 waits on rob1=3'd5; cdbValid=1 with cdbTag=5 in cycle 4 -> no grant in cycle 4, issueGrant=4'b0010 in cycle 5.
REQ-037 Alloc with rob2=3'd6 while cdbValid=1 and cdbTag=6 -> rdy2 stored as 1 and the entry is granted the next cycle.
REQ-038 Fill all 4 entries, assert flush together with fuReady=1 -> grant that cycle only, then ALUBusyVector=0 and issueValid=0.
REQ-039 Drive rst_n=0 for one edge with 3 valid ready entries -> all outputs 0, and no grant in the cycle after release.
